// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding rename; refilled by ROB commit.
// Optional same-cycle release-to-take bypass on an empty list: define FREE_LIST_BYPASS_EN.
module phys_reg_free_list #(
  parameter int unsigned REG_FILE_ADDR_WIDTH = 7,
  parameter int unsigned NUM_ARCH_REGS       = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           take_free_reg,
  output logic [REG_FILE_ADDR_WIDTH-1:0] free_reg,
  output logic                           reg_free_list_empty,
  input  logic                           release_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] release_reg,
  output logic [REG_FILE_ADDR_WIDTH-1:0] free_count,
  output logic                           overflow_err,
  output logic                           underflow_err
);

  localparam int unsigned W     = REG_FILE_ADDR_WIDTH;
  localparam int unsigned Depth = (1 << W) - NUM_ARCH_REGS;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam logic [W-1:0]    DepthW  = W'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [W-1:0]    mem [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [W-1:0]    count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            empty, push_req, bypass, bypass_take, pop_ok, push_ok;

  // Depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    push_req = release_valid && (release_reg != '0);
`ifdef FREE_LIST_BYPASS_EN
    bypass   = empty && push_req;
`else
    bypass   = 1'b0;
`endif
    bypass_take = bypass && take_free_reg;
    pop_ok      = take_free_reg && !empty;
    // A same-cycle pop frees a slot, so a push on a full list is still accepted.
    push_ok     = push_req && !bypass_take && ((count_q != DepthW) || pop_ok);

    ovf_d  = ovf_q | (push_req && !push_ok && !bypass_take);
    unf_d  = unf_q | (take_free_reg && empty && !bypass);
    head_d = pop_ok  ? ptr_inc(head_q) : head_q;
    tail_d = push_ok ? ptr_inc(tail_q) : tail_q;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    free_reg            = bypass ? release_reg : mem[head_q];
    reg_free_list_empty = empty && !bypass;
    free_count          = count_q;
    overflow_err        = ovf_q;
    underflow_err       = unf_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DepthW;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Tags below NUM_ARCH_REGS are pre-mapped, so the list starts with the rest.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= W'(NUM_ARCH_REGS + i);
      end
    end else if (push_ok) begin
      mem[tail_q] <= release_reg;
    end
  end

endmodule
